alu_issue_stage: RTL and testbench

Execute-stage front end that feeds the ALU. It accepts decoded operations over a valid/ready handshake and translates each opcode into the ALU control encoding (FnClass, LogicFn, ShiftFn, add_sub, ConstVar). It registers the operands onto the ALU inputs, then captures ALU_result/Overflow into a writeback register with its own valid/ready handshake. It sits between the decode stage and the register-file writeback path, with a 2-deep pipeline and full backpressure.

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_op_decode.sv | 75 +++++++
 rtl/alu_issue_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared types and constants for the ALU issue stage.
//
// Contents:
//   alu_op_e    : 4-bit operation code seen on in_op (values 0..15)
//   FN_*        : FnClass encodings driven to the ALU
//   LOGIC_*     : LogicFn sub-field encodings (FnClass LOGIC)
//   SHIFT_*     : ShiftFn sub-field encodings (FnClass SHIFT)
//   alu_ctrl_t  : bundle of ALU control fields produced by alu_op_decode
//   sext_imm()  : sign-extends the 16-bit immediate to the data width
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 16;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOR = 4'd5,
    OP_SLT = 4'd6,
    OP_SGT = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9,
    OP_SRA = 4'd10,
    OP_SL1 = 4'd11,
    OP_SR1 = 4'd12,
    OP_SA1 = 4'd13,
    OP_LUI = 4'd14,
    OP_HAM = 4'd15
  } alu_op_e;

  localparam logic [2:0] FN_LUI   = 3'b000;
  localparam logic [2:0] FN_SLT   = 3'b001;
  localparam logic [2:0] FN_SGT   = 3'b010;
  localparam logic [2:0] FN_ARITH = 3'b011;
  localparam logic [2:0] FN_LOGIC = 3'b100;
  localparam logic [2:0] FN_SHIFT = 3'b101;
  localparam logic [2:0] FN_HAM   = 3'b110;

  localparam logic [1:0] LOGIC_AND = 2'b00;
  localparam logic [1:0] LOGIC_OR  = 2'b01;
  localparam logic [1:0] LOGIC_XOR = 2'b10;
  localparam logic [1:0] LOGIC_NOR = 2'b11;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef struct packed {
    logic [2:0] fn_class;
    logic [1:0] logic_fn;
    logic [1:0] shift_fn;
    logic       add_sub;
    logic       const_var;
  } alu_ctrl_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode -- purely combinational translation of an operation code
// into the ALU control fields. Fields an operation does not use are 0.
//
// Ports:
//   op   in  alu_op_e    operation code
//   ctrl out alu_ctrl_t  {fn_class, logic_fn, shift_fn, add_sub, const_var}
module alu_op_decode
  import alu_pkg::*;
(
  input  alu_op_e   op,
  output alu_ctrl_t ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD: ctrl.fn_class = FN_ARITH;
      OP_SUB: begin
        ctrl.fn_class = FN_ARITH;
        ctrl.add_sub  = 1'b1;
      end
      OP_AND: begin
        ctrl.fn_class = FN_LOGIC;
        ctrl.logic_fn = LOGIC_AND;
      end
      OP_OR: begin
        ctrl.fn_class = FN_LOGIC;
        ctrl.logic_fn = LOGIC_OR;
      end
      OP_XOR: begin
        ctrl.fn_class = FN_LOGIC;
        ctrl.logic_fn = LOGIC_XOR;
      end
      OP_NOR: begin
        ctrl.fn_class = FN_LOGIC;
        ctrl.logic_fn = LOGIC_NOR;
      end
      OP_SLT: ctrl.fn_class = FN_SLT;
      OP_SGT: ctrl.fn_class = FN_SGT;
      // Variable-amount shifts take the amount from y.
      OP_SLL: begin
        ctrl.fn_class = FN_SHIFT;
        ctrl.shift_fn = SHIFT_SLL;
      end
      OP_SRL: begin
        ctrl.fn_class = FN_SHIFT;
        ctrl.shift_fn = SHIFT_SRL;
      end
      OP_SRA: begin
        ctrl.fn_class = FN_SHIFT;
        ctrl.shift_fn = SHIFT_SRA;
      end
      // Constant shifts move by exactly one bit, ignoring y.
      OP_SL1: begin
        ctrl.fn_class  = FN_SHIFT;
        ctrl.shift_fn  = SHIFT_SLL;
        ctrl.const_var = 1'b1;
      end
      OP_SR1: begin
        ctrl.fn_class  = FN_SHIFT;
        ctrl.shift_fn  = SHIFT_SRL;
        ctrl.const_var = 1'b1;
      end
      OP_SA1: begin
        ctrl.fn_class  = FN_SHIFT;
        ctrl.shift_fn  = SHIFT_SRA;
        ctrl.const_var = 1'b1;
      end
      OP_LUI: ctrl.fn_class = FN_LUI;
      OP_HAM: ctrl.fn_class = FN_HAM;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- execute-stage front end feeding a combinational ALU.
//
// Two register stages with full backpressure:
//   S1: on in_valid && in_ready the decoded controls and operands are loaded
//       onto the alu_* registers. They only change on an accept.
//   S2: while S1 holds an op and the writeback slot is free (or draining this
//       cycle), alu_result/alu_overflow are captured into out_*.
// An op accepted at edge N sits on alu_* after N, is captured into out_* at
// N+1, and the writeback consumer takes it at edge N+2.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         decode-side handshake
//   in_op, in_imm_sel, in_imm operation and y-operand selection
//   in_rs1_val, in_rs2_val    x operand, register y operand
//   in_rd                     destination register
//   alu_x, alu_y, alu_*       registered ALU operands and controls
//   alu_result, alu_overflow  combinational ALU outputs
//   out_valid/out_ready       writeback handshake
//   out_result, out_rd        captured result and destination
//   out_we                    write enable (rd != 0)
//   out_ovf                   overflow, masked to arithmetic ops only
//   out_trap                  only when ALU_OVF_TRAP_EN is defined: marks an
//                             overflowed arithmetic beat, which is not written
//                             back; new accepts stall until it is taken.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic              in_imm_sel,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_rs1_val,
  input  logic [DATA_W-1:0] in_rs2_val,
  input  logic [RD_W-1:0]   in_rd,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_add_sub,
  output logic              alu_ConstVar,
  output logic [1:0]        alu_LogicFn,
  output logic [1:0]        alu_ShiftFn,
  output logic [2:0]        alu_FnClass,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_we,
  output logic              out_ovf
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic              out_trap
`endif
);

  alu_op_e   op_in;
  alu_ctrl_t ctrl_dec;

  assign op_in = alu_op_e'(in_op);

  alu_op_decode u_dec (
    .op   (op_in),
    .ctrl (ctrl_dec)
  );

  // S1 registers
  logic [DATA_W-1:0] alu_x_q, alu_x_d;
  logic [DATA_W-1:0] alu_y_q, alu_y_d;
  alu_ctrl_t         ctrl_q, ctrl_d;
  logic [RD_W-1:0]   s1_rd_q, s1_rd_d;
  logic              s1_valid_q, s1_valid_d;

  // S2 registers
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [RD_W-1:0]   out_rd_q, out_rd_d;
  logic              out_we_q, out_we_d;
  logic              out_ovf_q, out_ovf_d;
`ifdef ALU_OVF_TRAP_EN
  logic              out_trap_q, out_trap_d;
`endif

  logic in_ready_int;
  logic accept;
  logic s2_load;
  logic ovf_masked;

  always_comb begin
    alu_x_d      = alu_x_q;
    alu_y_d      = alu_y_q;
    ctrl_d       = ctrl_q;
    s1_rd_d      = s1_rd_q;
    s1_valid_d   = s1_valid_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_we_d     = out_we_q;
    out_ovf_d    = out_ovf_q;
`ifdef ALU_OVF_TRAP_EN
    out_trap_d   = out_trap_q;
`endif

    // S1 is free if empty, or if its op moves to S2 this cycle (S2 empty or
    // draining). Both moves happen on the same edge, so there is no bubble.
    in_ready_int = !s1_valid_q || !out_valid_q || out_ready;
`ifdef ALU_OVF_TRAP_EN
    // Hold off new work until a pending trap beat has been taken.
    if (out_valid_q && out_trap_q) begin
      in_ready_int = 1'b0;
    end
`endif
    accept  = in_valid && in_ready_int;
    s2_load = s1_valid_q && (!out_valid_q || out_ready);

    // Overflow means nothing outside the add/sub class.
    ovf_masked = alu_overflow && (ctrl_q.fn_class == FN_ARITH);

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_rd_d     = s1_rd_q;
      out_ovf_d    = ovf_masked;
`ifdef ALU_OVF_TRAP_EN
      out_trap_d   = ovf_masked;
      out_we_d     = (s1_rd_q != '0) && !ovf_masked;
`else
      out_we_d     = (s1_rd_q != '0);
`endif
      s1_valid_d   = 1'b0;
    end

    if (accept) begin
      alu_x_d    = in_rs1_val;
      alu_y_d    = in_imm_sel ? sext_imm(in_imm) : in_rs2_val;
      ctrl_d     = ctrl_dec;
      s1_rd_d    = in_rd;
      s1_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      ctrl_q       <= '0;
      s1_rd_q      <= '0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_we_q     <= 1'b0;
      out_ovf_q    <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      out_trap_q   <= 1'b0;
`endif
    end else begin
      alu_x_q      <= alu_x_d;
      alu_y_q      <= alu_y_d;
      ctrl_q       <= ctrl_d;
      s1_rd_q      <= s1_rd_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_we_q     <= out_we_d;
      out_ovf_q    <= out_ovf_d;
`ifdef ALU_OVF_TRAP_EN
      out_trap_q   <= out_trap_d;
`endif
    end
  end

  assign in_ready     = in_ready_int;
  assign alu_x        = alu_x_q;
  assign alu_y        = alu_y_q;
  assign alu_FnClass  = ctrl_q.fn_class;
  assign alu_LogicFn  = ctrl_q.logic_fn;
  assign alu_ShiftFn  = ctrl_q.shift_fn;
  assign alu_add_sub  = ctrl_q.add_sub;
  assign alu_ConstVar = ctrl_q.const_var;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_rd       = out_rd_q;
  assign out_we       = out_we_q;
  assign out_ovf      = out_ovf_q;
`ifdef ALU_OVF_TRAP_EN
  assign out_trap     = out_trap_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage -- directed bench for alu_issue_stage.
// A small behavioural ALU sits on the alu_* outputs; for non-arithmetic
// classes it deliberately raises Overflow so that the masking is exercised.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_imm_sel;
  logic [15:0] in_imm;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic [4:0]  in_rd;
  logic [31:0] alu_x, alu_y;
  logic        alu_add_sub, alu_ConstVar;
  logic [1:0]  alu_LogicFn, alu_ShiftFn;
  logic [2:0]  alu_FnClass;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we, out_ovf;
`ifdef ALU_OVF_TRAP_EN
  logic        out_trap;
`endif

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_imm_sel   (in_imm_sel),
    .in_imm       (in_imm),
    .in_rs1_val   (in_rs1_val),
    .in_rs2_val   (in_rs2_val),
    .in_rd        (in_rd),
    .alu_x        (alu_x),
    .alu_y        (alu_y),
    .alu_add_sub  (alu_add_sub),
    .alu_ConstVar (alu_ConstVar),
    .alu_LogicFn  (alu_LogicFn),
    .alu_ShiftFn  (alu_ShiftFn),
    .alu_FnClass  (alu_FnClass),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_we       (out_we),
    .out_ovf      (out_ovf)
`ifdef ALU_OVF_TRAP_EN
    ,
    .out_trap     (out_trap)
`endif
  );

  // Behavioural ALU
  logic [31:0] m_sum;
  logic [4:0]  m_sh;
  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = 1'b1;
    m_sum        = 32'h0;
    m_sh         = alu_ConstVar ? 5'd1 : alu_y[4:0];
    case (alu_FnClass)
      3'b000: alu_result = {alu_y[15:0], 16'h0};
      3'b001: alu_result = {31'h0, ($signed(alu_x) < $signed(alu_y))};
      3'b010: alu_result = {31'h0, ($signed(alu_x) > $signed(alu_y))};
      3'b011: begin
        m_sum = alu_add_sub ? (alu_x - alu_y) : (alu_x + alu_y);
        alu_result = m_sum;
        if (alu_add_sub)
          alu_overflow = (alu_x[31] != alu_y[31]) && (m_sum[31] != alu_x[31]);
        else
          alu_overflow = (alu_x[31] == alu_y[31]) && (m_sum[31] != alu_x[31]);
      end
      3'b100: begin
        case (alu_LogicFn)
          2'b00: alu_result = alu_x & alu_y;
          2'b01: alu_result = alu_x | alu_y;
          2'b10: alu_result = alu_x ^ alu_y;
          default: alu_result = ~(alu_x | alu_y);
        endcase
      end
      3'b101: begin
        case (alu_ShiftFn)
          2'b00: alu_result = alu_x << m_sh;
          2'b01: alu_result = alu_x >> m_sh;
          2'b10: alu_result = $unsigned($signed(alu_x) >>> m_sh);
          default: alu_result = 32'h0;
        endcase
      end
      3'b110: alu_result = 32'($countones(alu_x));
      default: alu_result = 32'h0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        imm_sel;
    logic [15:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  fn;
    logic [1:0]  lf;
    logic [1:0]  sf;
    logic        as;
    logic        cv;
    logic [31:0] y;
    logic [31:0] res;
    logic        ovf;
    logic        we;
  } vec_t;

  vec_t vecs[18];

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_op      = 4'd0;
    in_imm_sel = 1'b0;
    in_imm     = 16'h0;
    in_rs1_val = 32'h0;
    in_rs2_val = 32'h0;
    in_rd      = 5'd0;
  endtask

  // Streams n_ops ADDs (x=k, y=100, rd=k+1); out_ready low for the first
  // `stall` cycles. Checks in-order delivery, the cycle in_ready first drops
  // (as the accept count at that point) and the cycle the last result leaves.
  task automatic run_stream(input int n_ops, input int stall, input int exp_block,
                            input int exp_last);
    int  acc = 0;
    int  got = 0;
    int  first_block = -1;
    int  last_cyc = -1;
    bit  do_acc;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      if (acc < n_ops) begin
        in_valid   = 1'b1;
        in_op      = 4'd0;
        in_imm_sel = 1'b0;
        in_rs1_val = 32'(acc);
        in_rs2_val = 32'd100;
        in_rd      = 5'(acc + 1);
      end else begin
        idle_inputs();
      end
      #1;
      if (in_valid && !in_ready && first_block < 0) first_block = acc;
      do_acc = in_valid && in_ready;
      if (out_valid) begin
        if (got >= n_ops) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stream_extra: got beat %h beyond %0d results", out_result, n_ops);
        end else begin
          chk("stream_result", out_result, 32'(100 + got));
          chk("stream_rd", 32'(out_rd), 32'(got + 1));
          if (out_ready) begin
            $display("stream beat %0d: result %h rd %0d cycle %0d", got, out_result, out_rd, cyc);
            got++;
            last_cyc = cyc;
          end
        end
      end
      @(posedge clk);
      if (do_acc) acc++;
    end
    chk("stream_accepted", 32'(acc), 32'(n_ops));
    chk("stream_count", 32'(got), 32'(n_ops));
    chk("stream_in_ready_drop", 32'(first_block), 32'(exp_block));
    chk("stream_last_cycle", 32'(last_cyc), 32'(exp_last));
    @(negedge clk);
    idle_inputs();
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  initial begin
    //          op  isel imm      rs1           rs2           rd     fn      lf    sf    as    cv    y             res           ovf   we
    vecs[0]  = '{4'd0, 1'b0, 16'h0000, 32'd10,       32'd5,        5'd3,  3'b011, 2'd0, 2'd0, 1'b0, 1'b0, 32'd5,        32'd15,       1'b0, 1'b1};
    vecs[1]  = '{4'd1, 1'b1, 16'h0001, 32'h80000000, 32'h0,        5'd4,  3'b011, 2'd0, 2'd0, 1'b1, 1'b0, 32'd1,        32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[2]  = '{4'd2, 1'b0, 16'h0000, 32'hAAAAAAAA, 32'h55555555, 5'd5,  3'b100, 2'd0, 2'd0, 1'b0, 1'b0, 32'h55555555, 32'h0,        1'b0, 1'b1};
    vecs[3]  = '{4'd3, 1'b0, 16'h0000, 32'hF0,       32'h0F,       5'd6,  3'b100, 2'd1, 2'd0, 1'b0, 1'b0, 32'h0F,       32'hFF,       1'b0, 1'b1};
    vecs[4]  = '{4'd4, 1'b0, 16'h0000, 32'hFF,       32'h0F,       5'd7,  3'b100, 2'd2, 2'd0, 1'b0, 1'b0, 32'h0F,       32'hF0,       1'b0, 1'b1};
    vecs[5]  = '{4'd5, 1'b1, 16'h0000, 32'h0,        32'h12345678, 5'd8,  3'b100, 2'd3, 2'd0, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{4'd6, 1'b0, 16'h0000, 32'hFFFFFFFF, 32'd1,        5'd9,  3'b001, 2'd0, 2'd0, 1'b0, 1'b0, 32'd1,        32'd1,        1'b0, 1'b1};
    vecs[7]  = '{4'd7, 1'b0, 16'h0000, 32'hFFFFFFFF, 32'd1,        5'd0,  3'b010, 2'd0, 2'd0, 1'b0, 1'b0, 32'd1,        32'd0,        1'b0, 1'b0};
    vecs[8]  = '{4'd8, 1'b0, 16'h0000, 32'd1,        32'd4,        5'd10, 3'b101, 2'd0, 2'd0, 1'b0, 1'b0, 32'd4,        32'h10,       1'b0, 1'b1};
    vecs[9]  = '{4'd9, 1'b0, 16'h0000, 32'h80000000, 32'd4,        5'd11, 3'b101, 2'd0, 2'd1, 1'b0, 1'b0, 32'd4,        32'h08000000, 1'b0, 1'b1};
    vecs[10] = '{4'd10, 1'b0, 16'h0000, 32'h80000000, 32'd1,       5'd12, 3'b101, 2'd0, 2'd2, 1'b0, 1'b0, 32'd1,        32'hC0000000, 1'b0, 1'b1};
    vecs[11] = '{4'd11, 1'b0, 16'h0000, 32'd3,        32'd7,       5'd13, 3'b101, 2'd0, 2'd0, 1'b0, 1'b1, 32'd7,        32'd6,        1'b0, 1'b1};
    vecs[12] = '{4'd12, 1'b0, 16'h0000, 32'h80000000, 32'd7,       5'd14, 3'b101, 2'd0, 2'd1, 1'b0, 1'b1, 32'd7,        32'h40000000, 1'b0, 1'b1};
    vecs[13] = '{4'd13, 1'b0, 16'h0000, 32'h80000000, 32'd7,       5'd15, 3'b101, 2'd0, 2'd2, 1'b0, 1'b1, 32'd7,        32'hC0000000, 1'b0, 1'b1};
    vecs[14] = '{4'd14, 1'b1, 16'hABCD, 32'h0,        32'h0,       5'd16, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 32'hFFFFABCD, 32'hABCD0000, 1'b0, 1'b1};
    vecs[15] = '{4'd15, 1'b0, 16'h0000, 32'hF0F0000F, 32'h0,       5'd17, 3'b110, 2'd0, 2'd0, 1'b0, 1'b0, 32'h0,        32'd12,       1'b0, 1'b1};
    vecs[16] = '{4'd0, 1'b1, 16'hFFFF, 32'h0,         32'h0,       5'd18, 3'b011, 2'd0, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[17] = '{4'd0, 1'b0, 16'h0000, 32'h7FFFFFFF, 32'd1,        5'd31, 3'b011, 2'd0, 2'd0, 1'b0, 1'b0, 32'd1,        32'h80000000, 1'b1, 1'b1};

    // Reset
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fnclass", 32'(alu_FnClass), 32'd0);
    chk("rst_alu_x", alu_x, 32'h0);
    chk("rst_alu_y", alu_y, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_flags", {out_we, out_ovf, 5'(out_rd)}, 32'h0);

    // Single-op vectors
    for (int i = 0; i < 18; i++) begin
      logic exp_we;
      exp_we = vecs[i].we;
`ifdef ALU_OVF_TRAP_EN
      if (vecs[i].ovf) exp_we = 1'b0;
`endif
      @(negedge clk);
      in_valid   = 1'b1;
      in_op      = vecs[i].op;
      in_imm_sel = vecs[i].imm_sel;
      in_imm     = vecs[i].imm;
      in_rs1_val = vecs[i].rs1;
      in_rs2_val = vecs[i].rs2;
      in_rd      = vecs[i].rd;
      chk("vec_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      // Garbage while idle: alu_* must not move without an accept.
      in_valid   = 1'b0;
      in_rs1_val = 32'hDEADBEEF;
      in_rs2_val = 32'hCAFEF00D;
      in_op      = 4'd9;
      chk("vec_fnclass", 32'(alu_FnClass), 32'(vecs[i].fn));
      chk("vec_logicfn", 32'(alu_LogicFn), 32'(vecs[i].lf));
      chk("vec_shiftfn", 32'(alu_ShiftFn), 32'(vecs[i].sf));
      chk("vec_add_sub", 32'(alu_add_sub), 32'(vecs[i].as));
      chk("vec_constvar", 32'(alu_ConstVar), 32'(vecs[i].cv));
      chk("vec_alu_x", alu_x, vecs[i].rs1);
      chk("vec_alu_y", alu_y, vecs[i].y);
      chk("vec_early_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk("vec_out_valid", 32'(out_valid), 32'd1);
      chk("vec_result", out_result, vecs[i].res);
      chk("vec_rd", 32'(out_rd), 32'(vecs[i].rd));
      chk("vec_we", 32'(out_we), 32'(exp_we));
      chk("vec_ovf", 32'(out_ovf), 32'(vecs[i].ovf));
`ifdef ALU_OVF_TRAP_EN
      chk("vec_trap", 32'(out_trap), 32'(vecs[i].ovf));
`endif
      chk("vec_alu_x_hold", alu_x, vecs[i].rs1);
      $display("vec %0d: op %0d result %h rd %0d we %0d ovf %0d", i, vecs[i].op,
               out_result, out_rd, out_we, out_ovf);
      @(posedge clk);
      #1;
      chk("vec_no_dup", 32'(out_valid), 32'd0);
      idle_inputs();
    end

    // Backpressure: 4 ops, out_ready low for 3 cycles
    run_stream(4, 3, 2, 6);
    // Full throughput: 3 ops with out_ready high
    run_stream(3, 0, -1, 4);

    // Reset with both stages full
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_op      = 4'd1;
    in_rs1_val = 32'd50;
    in_rs2_val = 32'd8;
    in_rd      = 5'd2;
    @(negedge clk);
    in_rs1_val = 32'd60;
    in_rd      = 5'd3;
    chk("full_in_ready1", 32'(in_ready), 32'd1);
    @(negedge clk);
    idle_inputs();
    chk("full_in_ready0", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_result", out_result, 32'd42);
    chk("full_fnclass", 32'(alu_FnClass), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_fnclass", 32'(alu_FnClass), 32'd0);
    chk("midrst_alu_x", alu_x, 32'h0);
    $display("mid-stream reset: out_valid %0d in_ready %0d", out_valid, in_ready);
    @(posedge clk);
    #1;
    chk("midrst_dropped", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
